// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 5-stage pipeline: shadows the ID/EX, EX/MEM, MEM/WB
// hazard fields and drives the EX operand-mux selects. FWD_STALL_CNT_EN adds a stall-cycle counter.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rt_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        fwd_a_sel_o,
  output logic [1:0]        fwd_b_sel_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam logic [1:0] SelRf  = 2'b00;
  localparam logic [1:0] SelMem = 2'b01;
  localparam logic [1:0] SelWb  = 2'b10;

  logic [REG_AW-1:0] ex_rs_q, ex_rt_q, ex_rd_q, mem_rd_q, wb_rd_q;
  logic              ex_use_rt_q, ex_regwrite_q, ex_memread_q;
  logic              mem_regwrite_q, mem_memread_q, wb_regwrite_q;
  logic              ex_take;

  // A stalled, flushed or empty ID slot enters EX as a fully cleared bubble.
  assign ex_take = id_valid_i & ~stall_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_use_rt_q    <= 1'b0;
      ex_regwrite_q  <= 1'b0;
      ex_memread_q   <= 1'b0;
      mem_rd_q       <= '0;
      mem_regwrite_q <= 1'b0;
      mem_memread_q  <= 1'b0;
      wb_rd_q        <= '0;
      wb_regwrite_q  <= 1'b0;
    end else begin
      wb_rd_q        <= mem_rd_q;
      wb_regwrite_q  <= mem_regwrite_q;
      mem_rd_q       <= ex_rd_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_memread_q  <= ex_memread_q;
      if (ex_take) begin
        ex_rs_q       <= id_rs_i;
        ex_rt_q       <= id_rt_i;
        ex_rd_q       <= id_rd_i;
        ex_use_rt_q   <= id_use_rt_i;
        ex_regwrite_q <= id_regwrite_i;
        ex_memread_q  <= id_memread_i;
      end else begin
        ex_rs_q       <= '0;
        ex_rt_q       <= '0;
        ex_rd_q       <= '0;
        ex_use_rt_q   <= 1'b0;
        ex_regwrite_q <= 1'b0;
        ex_memread_q  <= 1'b0;
      end
    end
  end

  logic mem_a_hit, wb_a_hit, mem_b_hit, wb_b_hit;

  assign mem_a_hit = mem_regwrite_q & (mem_rd_q != '0) & (mem_rd_q == ex_rs_q);
  assign wb_a_hit  = wb_regwrite_q & (wb_rd_q != '0) & (wb_rd_q == ex_rs_q);
  assign mem_b_hit = mem_regwrite_q & (mem_rd_q != '0) & (mem_rd_q == ex_rt_q);
  assign wb_b_hit  = wb_regwrite_q & (wb_rd_q != '0) & (wb_rd_q == ex_rt_q);

  // The younger result in MEM takes priority over WB.
  always_comb begin
    fwd_a_sel_o = SelRf;
    if (mem_a_hit)     fwd_a_sel_o = SelMem;
    else if (wb_a_hit) fwd_a_sel_o = SelWb;

    fwd_b_sel_o = SelRf;
    if (ex_use_rt_q) begin
      if (mem_b_hit)     fwd_b_sel_o = SelMem;
      else if (wb_b_hit) fwd_b_sel_o = SelWb;
    end
  end

  assign stall_o = id_valid_i & ex_memread_q & ex_regwrite_q & (ex_rd_q != '0) &
                   ((ex_rd_q == id_rs_i) | (id_use_rt_i & (ex_rd_q == id_rt_i)));

`ifdef FWD_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && !flush_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: forwarding selects, load-use stall, flush and reset cases.
module tb_fwd_hazard_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic        id_use_rt_i, id_regwrite_i, id_memread_i, flush_i;
  logic [1:0]  fwd_a_sel_o, fwd_b_sel_o;
  logic        stall_o;
  logic [31:0] stall_cnt_o;

  int n_checks = 0;
  int n_errors = 0;

`ifdef FWD_STALL_CNT_EN
  localparam logic [31:0] CntStep = 32'd1;
`else
  localparam logic [31:0] CntStep = 32'd0;
`endif

  fwd_hazard_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .id_valid_i   (id_valid_i),
    .id_rs_i      (id_rs_i),
    .id_rt_i      (id_rt_i),
    .id_use_rt_i  (id_use_rt_i),
    .id_rd_i      (id_rd_i),
    .id_regwrite_i(id_regwrite_i),
    .id_memread_i (id_memread_i),
    .flush_i      (flush_i),
    .fwd_a_sel_o  (fwd_a_sel_o),
    .fwd_b_sel_o  (fwd_b_sel_o),
    .stall_o      (stall_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic use_rt, input logic [4:0] rd, input logic rw,
                        input logic mr);
    id_valid_i    = v;
    id_rs_i       = rs;
    id_rt_i       = rt;
    id_use_rt_i   = use_rt;
    id_rd_i       = rd;
    id_regwrite_i = rw;
    id_memread_i  = mr;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    flush_i = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    rst_i   = 1'b0;
    flush_i = 1'b0;
    // Random inputs while held in reset.
    for (int i = 0; i < 4; i++) begin
      set_id(1'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
             1'($urandom), 1'($urandom));
      flush_i = 1'($urandom);
      tick();
    end
    check("rst_a_sel", 32'(fwd_a_sel_o), 32'd0);
    check("rst_b_sel", 32'(fwd_b_sel_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_cnt", stall_cnt_o, 32'd0);
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    flush_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();

    // EX/MEM forward: add $3 ; sub rs=3 rt=4
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd3, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0); tick();
    check("exmem_a", 32'(fwd_a_sel_o), 32'd1);
    check("exmem_b", 32'(fwd_b_sel_o), 32'd0);
    drain();

    // Double hazard: add $5 ; add $5 ; or rs=5 rt=5
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0); tick();
    check("double_a", 32'(fwd_a_sel_o), 32'd1);
    check("double_b", 32'(fwd_b_sel_o), 32'd1);
    drain();

    // MEM/WB forward: add $7 ; nop ; and rs=7 rt=9
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0); tick();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); tick();
    set_id(1'b1, 5'd7, 5'd9, 1'b1, 5'd10, 1'b1, 1'b0); tick();
    check("memwb_a", 32'(fwd_a_sel_o), 32'd2);
    check("memwb_b", 32'(fwd_b_sel_o), 32'd0);
    drain();

    // Operand B gated by use_rt, then taken through rt when used.
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd7, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd0, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0); tick();
    check("no_use_rt_b", 32'(fwd_b_sel_o), 32'd0);
    set_id(1'b1, 5'd0, 5'd7, 1'b1, 5'd11, 1'b1, 1'b0); tick();
    check("use_rt_b", 32'(fwd_b_sel_o), 32'd1);
    check("use_rt_a_r0", 32'(fwd_a_sel_o), 32'd0);
    drain();

    // Register zero never forwards.
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd4, 1'b1, 1'b0); tick();
    check("r0_a", 32'(fwd_a_sel_o), 32'd0);
    check("r0_b", 32'(fwd_b_sel_o), 32'd0);
    drain();

    // Load-use with simultaneous flush: bubble, counter untouched.
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd2, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    flush_i = 1'b1;
    #1;
    check("flush_stall", 32'(stall_o), 32'd1);
    tick();
    flush_i = 1'b0;
    #1;
    check("flush_cnt", stall_cnt_o, 32'd0);
    check("flush_bubble_stall", 32'(stall_o), 32'd0);
    drain();

    // Load-use: lw $2 ; add rs=2 -> one stall cycle, then WB forward.
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd2, 5'd3, 1'b1, 5'd4, 1'b1, 1'b0);
    #1;
    check("lu_stall", 32'(stall_o), 32'd1);
    tick();
    check("lu_stall_clear", 32'(stall_o), 32'd0);
    check("lu_bubble_a", 32'(fwd_a_sel_o), 32'd0);
    check("lu_cnt", stall_cnt_o, CntStep);
    tick();
    check("lu_fwd_a", 32'(fwd_a_sel_o), 32'd2);
    check("lu_fwd_b", 32'(fwd_b_sel_o), 32'd0);
    check("lu_cnt_hold", stall_cnt_o, CntStep);
    drain();

    // Load-use through rt, gated by use_rt and id_valid.
    set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd1, 5'd6, 1'b1, 5'd4, 1'b1, 1'b0); #1;
    check("lu_rt_stall", 32'(stall_o), 32'd1);
    set_id(1'b1, 5'd1, 5'd6, 1'b0, 5'd4, 1'b1, 1'b0); #1;
    check("lu_rt_unused", 32'(stall_o), 32'd0);
    set_id(1'b0, 5'd6, 5'd6, 1'b1, 5'd4, 1'b1, 1'b0); #1;
    check("lu_invalid", 32'(stall_o), 32'd0);
    drain();

    // Asynchronous reset mid-operation clears selects without a clock.
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0); tick();
    check("pre_rst_a", 32'(fwd_a_sel_o), 32'd1);
    #1;
    rst_i = 1'b0;
    #1;
    check("async_rst_a", 32'(fwd_a_sel_o), 32'd0);
    check("async_rst_b", 32'(fwd_b_sel_o), 32'd0);
    check("async_rst_cnt", stall_cnt_o, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
